// File: rtl/dram_clk_ctl_pkg.sv
// Shared types and constants for the DRAM clock-pad enable sequencer.
package dram_clk_ctl_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENABLE  = 3'd1,
    SETTLE  = 3'd2,
    RUN     = 3'd3,
    DISABLE = 3'd4
  } clk_state_e;

  // A programmed value of zero behaves like these minimums.
  localparam int unsigned MIN_STAGGER = 1;
  localparam int unsigned MIN_SETTLE  = 1;

endpackage : dram_clk_ctl_pkg

// File: rtl/dram_clk_ctl_cnt.sv
// Loadable down-counter with a zero flag. Stops at zero and never wraps.
module dram_clk_ctl_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority over decrement; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule : dram_clk_ctl_cnt

// File: rtl/dram_clk_enable_ctl.sv
// DRAM clock-pad sequencer: brings the per-pad edge-logic enables and
// clock-run gates up in ascending pad order and down in descending order,
// with a programmable stagger between pads and a settle wait before RUN.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | all pads off, waiting for clk_start
// ENABLE  | walking pads upward: enable, then clk_value one cycle later
// SETTLE  | all pads running, waiting settle_cycles before declaring stable
// RUN     | clocks stable, outputs held until clk_stop
// DISABLE | walking pads downward: clk_value off, then enable one cycle later
module dram_clk_enable_ctl
  import dram_clk_ctl_pkg::*;
#(
  parameter int NUM_CLK  = 4,
  parameter int SETTLE_W = 8,
  parameter int STAG_W   = 4
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                clk_start,
  input  logic                clk_stop,
  input  logic [NUM_CLK-1:0]  pad_mask,
  input  logic [STAG_W-1:0]   stagger_cycles,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic [NUM_CLK-1:0]  dram_io_clk_enable,
  output logic [NUM_CLK-1:0]  clk_value,
  output logic                clk_stable,
  output logic                clk_busy,
  output logic                clk_on_done,
  output logic                clk_off_done
);

  localparam int IDX_W = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLK - 1);

  clk_state_e          r_state;
  logic [IDX_W-1:0]    r_idx;
  logic                r_phase;
  logic [NUM_CLK-1:0]  r_mask;
  logic [STAG_W-1:0]   r_stag_m1;
  logic [SETTLE_W-1:0] r_settle_m1;
  logic [NUM_CLK-1:0]  r_en;
  logic [NUM_CLK-1:0]  r_val;
  logic                r_stable;
  logic                r_busy;
  logic                r_on_done;
  logic                r_off_done;

  logic                w_start_acc;
  logic                w_stop_acc;
  logic [STAG_W-1:0]   w_stag_eff;
  logic [STAG_W-1:0]   w_stag_m1;
  logic [SETTLE_W-1:0] w_settle_eff;
  logic [SETTLE_W-1:0] w_settle_m1;
  logic [IDX_W-1:0]    w_idx_up;
  logic [IDX_W-1:0]    w_idx_dn;
  logic [IDX_W-1:0]    w_hi_idx;
  logic                w_stag_load;
  logic [STAG_W-1:0]   w_stag_load_val;
  logic                w_stag_dec;
  logic                w_stag_zero;
  logic                w_settle_load;
  logic                w_settle_dec;
  logic                w_settle_zero;

  // Stop beats start; start only counts in IDLE, stop only while powering/running.
  assign w_start_acc = (r_state == IDLE) && clk_start && !clk_stop;
  assign w_stop_acc  = clk_stop && (r_state inside {ENABLE, SETTLE, RUN});

  // Zero-programmed stagger/settle behave as the minimum of one cycle.
  assign w_stag_eff   = (stagger_cycles < STAG_W'(MIN_STAGGER)) ? STAG_W'(MIN_STAGGER)
                                                                : stagger_cycles;
  assign w_stag_m1    = w_stag_eff - STAG_W'(1);
  assign w_settle_eff = (settle_cycles < SETTLE_W'(MIN_SETTLE)) ? SETTLE_W'(MIN_SETTLE)
                                                                : settle_cycles;
  assign w_settle_m1  = w_settle_eff - SETTLE_W'(1);

  assign w_idx_up = r_idx + IDX_W'(1);
  assign w_idx_dn = r_idx - IDX_W'(1);

  // Turn-off begins at the highest pad currently enabled (pad 0 if none are).
  always_comb begin
    w_hi_idx = '0;
    for (int i = 0; i < NUM_CLK; i++) begin
      if (r_en[i]) w_hi_idx = IDX_W'(i);
    end
  end

  // Stagger counter: freshly sampled on an accepted start/stop, otherwise
  // reloaded from the held copy each time the walk moves to the next pad.
  always_comb begin
    w_stag_load     = 1'b0;
    w_stag_load_val = r_stag_m1;
    w_stag_dec      = 1'b0;
    if (w_start_acc || w_stop_acc) begin
      w_stag_load     = 1'b1;
      w_stag_load_val = w_stag_m1;
    end else if (r_state == ENABLE) begin
      w_stag_dec  = 1'b1;
      w_stag_load = w_stag_zero && (r_idx != LAST_IDX);
    end else if (r_state == DISABLE) begin
      w_stag_dec  = 1'b1;
      w_stag_load = w_stag_zero && (r_idx != '0);
    end
  end

  // Settle counter is armed on the last ENABLE cycle and runs during SETTLE.
  assign w_settle_load = (r_state == ENABLE) && (r_idx == LAST_IDX) && r_phase;
  assign w_settle_dec  = (r_state == SETTLE);

  dram_clk_ctl_cnt #(.W(STAG_W)) u_stag_cnt (
    .clk        (clk),
    .rst_l      (rst_l),
    .i_load     (w_stag_load),
    .i_load_val (w_stag_load_val),
    .i_dec      (w_stag_dec),
    .o_zero     (w_stag_zero)
  );

  dram_clk_ctl_cnt #(.W(SETTLE_W)) u_settle_cnt (
    .clk        (clk),
    .rst_l      (rst_l),
    .i_load     (w_settle_load),
    .i_load_val (r_settle_m1),
    .i_dec      (w_settle_dec),
    .o_zero     (w_settle_zero)
  );

  // Sequencer FSM; every pad-facing and status output is a flop.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_phase     <= 1'b0;
      r_mask      <= '0;
      r_stag_m1   <= '0;
      r_settle_m1 <= '0;
      r_en        <= '0;
      r_val       <= '0;
      r_stable    <= 1'b0;
      r_busy      <= 1'b0;
      r_on_done   <= 1'b0;
      r_off_done  <= 1'b0;
    end else begin
      r_on_done  <= 1'b0;
      r_off_done <= 1'b0;
      if (w_stop_acc) begin
        // The top pad's run gate drops now; its enable follows next cycle.
        // A pad enabled but not yet running keeps clk_value at 0.
        r_state         <= DISABLE;
        r_stable        <= 1'b0;
        r_idx           <= w_hi_idx;
        r_phase         <= 1'b1;
        r_stag_m1       <= w_stag_m1;
        r_val[w_hi_idx] <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_start_acc) begin
              r_state     <= ENABLE;
              r_busy      <= 1'b1;
              r_mask      <= pad_mask;
              r_stag_m1   <= w_stag_m1;
              r_settle_m1 <= w_settle_m1;
              r_idx       <= '0;
              r_phase     <= 1'b0;
              r_en[0]     <= pad_mask[0];
            end
          end
          ENABLE: begin
            // Each enabled pad starts running exactly one cycle after its enable.
            r_val <= r_val | r_en;
            if (r_idx == LAST_IDX) begin
              if (r_phase) begin
                r_state <= SETTLE;
                r_phase <= 1'b0;
              end else begin
                r_phase <= 1'b1;
              end
            end else if (w_stag_zero) begin
              r_idx          <= w_idx_up;
              r_en[w_idx_up] <= r_mask[w_idx_up];
            end
          end
          SETTLE: begin
            if (w_settle_zero) begin
              r_state   <= RUN;
              r_stable  <= 1'b1;
              r_on_done <= 1'b1;
            end
          end
          RUN: begin
            r_state <= RUN;
          end
          DISABLE: begin
            if (r_phase) r_en[r_idx] <= 1'b0;
            if (r_idx == '0) begin
              if (r_phase) begin
                r_phase <= 1'b0;
              end else begin
                r_state    <= IDLE;
                r_busy     <= 1'b0;
                r_off_done <= 1'b1;
              end
            end else if (w_stag_zero) begin
              r_idx           <= w_idx_dn;
              r_val[w_idx_dn] <= 1'b0;
              r_phase         <= 1'b1;
            end else begin
              r_phase <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign dram_io_clk_enable = r_en;
  assign clk_value          = r_val;
  assign clk_stable         = r_stable;
  assign clk_busy           = r_busy;
  assign clk_on_done        = r_on_done;
  assign clk_off_done       = r_off_done;

endmodule : dram_clk_enable_ctl
